// File: rtl/uc_move_asteroides_tiros.sv
// Movement/collision control unit: one pass over every asteroid slot, then every shot slot.
// Optional macro UC_MOVE_DIVISOR_EN: asteroids move only once every DIV_AST passes.
module uc_move_asteroides_tiros #(
  parameter int N_AST   = 8,
  parameter int N_TIRO  = 4,
  parameter int DIV_AST = 4,
  localparam int AW = (N_AST  > 1) ? $clog2(N_AST)  : 1,
  localparam int TW = (N_TIRO > 1) ? $clog2(N_TIRO) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          vidas,
  input  logic          asteroide_ativo,
  input  logic          tiro_ativo,
  input  logic          colisao_nave,
  input  logic          colisao_tiro,
  input  logic [AW-1:0] tiro_alvo,
  output logic [AW-1:0] addr_asteroide,
  output logic [TW-1:0] addr_tiro,
  output logic          move_asteroide,
  output logic          move_tiro,
  output logic          destroi_asteroide,
  output logic          destroi_tiro,
  output logic          decrementa_vida,
  output logic          fim_movimentacao,
  output logic [3:0]    db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL      = 4'd0,
    S_PREPARA      = 4'd1,
    S_CARREGA_AST  = 4'd2,
    S_MOVE_AST     = 4'd3,
    S_CHECA_NAVE   = 4'd4,
    S_CARREGA_TIRO = 4'd5,
    S_MOVE_TIRO    = 4'd6,
    S_CHECA_TIRO   = 4'd7,
    S_FIM          = 4'd8
  } estado_t;

  estado_t       r_estado;
  estado_t       w_proximo;
  logic [AW-1:0] r_idxA;
  logic [TW-1:0] r_idxT;
  logic          w_moveOk;
  logic          w_ultimoAst;
  logic          w_ultimoTiro;

  assign w_ultimoAst  = (r_idxA == AW'(N_AST - 1));
  assign w_ultimoTiro = (r_idxT == TW'(N_TIRO - 1));

`ifdef UC_MOVE_DIVISOR_EN
  localparam int CW = (DIV_AST > 1) ? $clog2(DIV_AST) : 1;

  logic [CW-1:0] r_contaPasse;
  logic          r_moveOk;

  // Pass counter is sampled in PREPARA, so move_ok stays stable for the whole pass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_contaPasse <= '0;
      r_moveOk     <= 1'b0;
    end else if (r_estado == S_PREPARA) begin
      r_moveOk     <= (r_contaPasse == '0);
      r_contaPasse <= (r_contaPasse == CW'(DIV_AST - 1)) ? '0 : r_contaPasse + CW'(1);
    end
  end

  assign w_moveOk = r_moveOk;
`else
  // DIV_AST is at least 1, so asteroids move every pass.
  assign w_moveOk = (DIV_AST > 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= S_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idxA <= '0;
      r_idxT <= '0;
    end else begin
      case (r_estado)
        S_PREPARA: begin
          r_idxA <= '0;
          r_idxT <= '0;
        end
        S_CHECA_NAVE: begin
          if (vidas && !w_ultimoAst) begin
            r_idxA <= r_idxA + AW'(1);
          end
        end
        S_CHECA_TIRO: begin
          if (!w_ultimoTiro) begin
            r_idxT <= r_idxT + TW'(1);
          end
        end
        default: begin
          r_idxA <= r_idxA;
          r_idxT <= r_idxT;
        end
      endcase
    end
  end

  always_comb begin
    w_proximo         = r_estado;
    addr_asteroide    = r_idxA;
    move_asteroide    = 1'b0;
    move_tiro         = 1'b0;
    destroi_asteroide = 1'b0;
    destroi_tiro      = 1'b0;
    decrementa_vida   = 1'b0;
    fim_movimentacao  = 1'b0;
    case (r_estado)
      S_INICIAL: begin
        if (iniciar) begin
          w_proximo = S_PREPARA;
        end
      end
      S_PREPARA: begin
        w_proximo = S_CARREGA_AST;
      end
      S_CARREGA_AST: begin
        w_proximo = S_MOVE_AST;
      end
      S_MOVE_AST: begin
        move_asteroide = asteroide_ativo & w_moveOk;
        w_proximo      = S_CHECA_NAVE;
      end
      S_CHECA_NAVE: begin
        if (asteroide_ativo && colisao_nave) begin
          decrementa_vida   = 1'b1;
          destroi_asteroide = 1'b1;
        end
        if (!vidas) begin
          w_proximo = S_FIM;
        end else if (w_ultimoAst) begin
          w_proximo = S_CARREGA_TIRO;
        end else begin
          w_proximo = S_CARREGA_AST;
        end
      end
      S_CARREGA_TIRO: begin
        w_proximo = S_MOVE_TIRO;
      end
      S_MOVE_TIRO: begin
        move_tiro = tiro_ativo;
        w_proximo = S_CHECA_TIRO;
      end
      S_CHECA_TIRO: begin
        // The asteroid address is borrowed for the shot's target only during a hit.
        if (tiro_ativo && colisao_tiro) begin
          destroi_tiro      = 1'b1;
          destroi_asteroide = 1'b1;
          addr_asteroide    = tiro_alvo;
        end
        w_proximo = w_ultimoTiro ? S_FIM : S_CARREGA_TIRO;
      end
      S_FIM: begin
        fim_movimentacao = 1'b1;
        w_proximo        = S_INICIAL;
      end
      default: begin
        w_proximo = S_INICIAL;
      end
    endcase
  end

  assign addr_tiro = r_idxT;
  assign db_estado = r_estado;

endmodule
